// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
// Coprocessor-0 at the end of the M stage. Holds SR, Cause, EPC and PRId,
// serves mfc0 reads / mtc0 writes, decides whether the M-stage instruction
// is taken as an exception or interrupt victim, and clears EXL on eret.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   A1                  mfc0 read register number (DOut is combinational)
//   A2, DIn, WE         mtc0 write register number, data, enable
//   VPC, BD             victim PC and branch-delay-slot flag
//   Err, ExcCodeIn      synchronous exception flag and code from M stage
//   HWInt               six hardware interrupt lines
//   EXLClr              eret in M stage
//   IntReq              take exception/interrupt this cycle
//   EPC                 current EPC register (eret target)
//   HandlerPC           exception entry address
//   DOut                mfc0 read data
module cp0_exc_unit #(
   parameter logic [31:0] PRID       = 32'h2020_0007,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BD,
   input  logic        Err,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        IntReq,
   output logic [31:0] EPC,
   output logic [31:0] HandlerPC,
   output logic [31:0] DOut
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd_q;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   // EPC
   logic [31:0] epc_q;

   logic        int_pend;
   logic        exc_pend;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // EXL masks both sources, so a handler can never be re-entered.
   assign int_pend = (|(HWInt & im)) & ie & ~exl;
   assign exc_pend = Err & ~exl;
   assign IntReq   = int_pend | exc_pend;

   assign EPC       = epc_q;
   assign HandlerPC = HANDLER_PC;

   assign sr_word    = {16'h0000, im, 8'h00, exl, ie};
   assign cause_word = {bd_q, 15'h0000, ip, 3'b000, exc_code, 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd_q     <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc_q    <= '0;
      end else begin
         ip <= HWInt;
         if (IntReq) begin
            // Any mtc0 this cycle is the victim or is being flushed: drop it.
            exl      <= 1'b1;
            exc_code <= int_pend ? 5'd0 : ExcCodeIn;
            bd_q     <= BD;
            epc_q    <= BD ? (VPC - 32'd4) : VPC;
         end else begin
            if (WE && (A2 == REG_SR)) begin
               im  <= DIn[15:10];
               exl <= DIn[1];
               ie  <= DIn[0];
            end
            if (WE && (A2 == REG_EPC)) begin
               epc_q <= DIn;
            end
            // Placed after the SR write so eret wins for EXL only.
            if (EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      DOut = '0;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc_q;
         REG_PRID:  DOut = PRID;
         default:   DOut = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit
// Scoreboard bench for cp0_exc_unit: expected values are queued as stimulus
// is applied and popped/compared when the DUT outputs are sampled.
module tb_cp0_exc_unit;

   localparam logic [31:0] PRID_V    = 32'h2020_0007;
   localparam logic [31:0] HANDLER_V = 32'h0000_4180;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] VPC;
   logic        BD;
   logic        Err;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] HandlerPC;
   logic [31:0] DOut;

   int unsigned total;
   int unsigned bad;

   typedef struct {
      string       tag;
      logic [1:0]  kind;   // 0: DOut at a1, 1: IntReq, 2: EPC port, 3: HandlerPC
      logic [4:0]  a1;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   cp0_exc_unit #(
      .PRID       (PRID_V),
      .HANDLER_PC (HANDLER_V)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .DIn       (DIn),
      .WE        (WE),
      .VPC       (VPC),
      .BD        (BD),
      .Err       (Err),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .IntReq    (IntReq),
      .EPC       (EPC),
      .HandlerPC (HandlerPC),
      .DOut      (DOut)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.kind = 2'd0; e.a1 = a; e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_irq(input string tag, input logic v);
      exp_t e;
      e.tag = tag; e.kind = 2'd1; e.a1 = 5'd0; e.val = {31'd0, v};
      sb.push_back(e);
   endtask

   task automatic exp_epc(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.kind = 2'd2; e.a1 = 5'd0; e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_hpc(input string tag);
      exp_t e;
      e.tag = tag; e.kind = 2'd3; e.a1 = 5'd0; e.val = HANDLER_V;
      sb.push_back(e);
   endtask

   // Pop every queued expectation and compare against the live outputs.
   task automatic drain();
      exp_t e;
      logic [31:0] got;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         A1 = e.a1;
         #1;
         case (e.kind)
            2'd0:    got = DOut;
            2'd1:    got = {31'd0, IntReq};
            2'd2:    got = EPC;
            default: got = HandlerPC;
         endcase
         check_val(e.tag, got, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; WE = 1'b0; A2 = 5'd0; DIn = '0; Err = 1'b0;
      ExcCodeIn = 5'd0; BD = 1'b0; VPC = '0; HWInt = '0; EXLClr = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      A1    = 5'd0;
      idle();

      // Reset with exception, interrupts and a write all active
      reset = 1'b1; Err = 1'b1; ExcCodeIn = 5'd12; HWInt = 6'h3f;
      WE = 1'b1; A2 = 5'd14; DIn = 32'hffff_ffff;
      tick();
      idle();
      exp_irq("rst_irq", 1'b0);
      exp_rd("rst_sr", 5'd12, 32'h0);
      exp_rd("rst_cause", 5'd13, 32'h0);
      exp_rd("rst_epc", 5'd14, 32'h0);
      exp_rd("rst_prid", 5'd15, PRID_V);
      exp_epc("rst_epc_port", 32'h0);
      exp_hpc("handler_pc");
      drain();

      // mtc0 SR: IM=000011, IE=1
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0c01;
      exp_irq("mtc0_sr_irq", 1'b0);
      exp_rd("no_bypass_sr", 5'd12, 32'h0);
      drain();
      tick();
      idle();
      exp_rd("sr_written", 5'd12, 32'h0000_0c01);
      drain();

      // Timer0 interrupt
      HWInt = 6'b000001; VPC = 32'h0000_1000;
      exp_irq("int_irq", 1'b1);
      drain();
      tick();
      exp_irq("int_masked_exl", 1'b0);
      exp_rd("int_cause", 5'd13, 32'h0000_0400);
      exp_rd("int_sr", 5'd12, 32'h0000_0c03);
      exp_rd("int_epc", 5'd14, 32'h0000_1000);
      exp_epc("int_epc_port", 32'h0000_1000);
      drain();

      // eret with interrupt still asserted; it fires the cycle after
      EXLClr = 1'b1;
      exp_irq("eret_irq", 1'b0);
      drain();
      tick();
      EXLClr = 1'b0; VPC = 32'h0000_2000;
      exp_irq("post_eret_irq", 1'b1);
      exp_rd("post_eret_sr", 5'd12, 32'h0000_0c01);
      drain();
      tick();
      idle();
      exp_rd("int2_epc", 5'd14, 32'h0000_2000);
      drain();
      EXLClr = 1'b1;
      tick();
      idle();

      // Address exception in a delay slot
      Err = 1'b1; ExcCodeIn = 5'd5; BD = 1'b1; VPC = 32'h0000_3008;
      exp_irq("ades_irq", 1'b1);
      drain();
      tick();
      Err = 1'b1; ExcCodeIn = 5'd10; BD = 1'b0; VPC = 32'h0000_5000;
      exp_irq("nested_err_irq", 1'b0);
      exp_rd("ades_cause", 5'd13, 32'h8000_0014);
      exp_rd("ades_epc", 5'd14, 32'h0000_3004);
      exp_rd("ades_sr", 5'd12, 32'h0000_0c03);
      drain();
      tick();
      idle();
      exp_rd("nested_cause", 5'd13, 32'h8000_0014);
      exp_rd("nested_epc", 5'd14, 32'h0000_3004);
      drain();

      // eret with simultaneous mtc0 SR
      EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
      exp_irq("eret_wr_irq", 1'b0);
      drain();
      tick();
      idle();
      exp_rd("eret_wr_sr", 5'd12, 32'h0000_0401);
      drain();

      // Interrupt and Ov together, plus a dropped mtc0 EPC
      HWInt = 6'b000001; Err = 1'b1; ExcCodeIn = 5'd12; VPC = 32'h0000_6000;
      WE = 1'b1; A2 = 5'd14; DIn = 32'hdead_beef;
      exp_irq("prio_irq", 1'b1);
      drain();
      tick();
      idle();
      exp_rd("prio_cause", 5'd13, 32'h0000_0400);
      exp_rd("prio_epc", 5'd14, 32'h0000_6000);
      exp_rd("prio_sr", 5'd12, 32'h0000_0403);
      drain();
      EXLClr = 1'b1;
      tick();
      idle();

      // Read map and read-only registers
      exp_rd("rd_a0", 5'd0, 32'h0);
      exp_rd("rd_a16", 5'd16, 32'h0);
      exp_rd("rd_a31", 5'd31, 32'h0);
      exp_rd("cause_pre", 5'd13, 32'h0);
      drain();
      WE = 1'b1; A2 = 5'd13; DIn = 32'hffff_ffff;
      tick();
      A2 = 5'd15;
      exp_rd("cause_ro", 5'd13, 32'h0);
      drain();
      tick();
      A2 = 5'd14; DIn = 32'h1234_5678;
      exp_rd("prid_ro", 5'd15, PRID_V);
      exp_rd("epc_no_bypass", 5'd14, 32'h0000_6000);
      drain();
      tick();
      idle();
      exp_rd("epc_mtc0", 5'd14, 32'h1234_5678);
      exp_rd("sr_kept", 5'd12, 32'h0000_0401);
      drain();

      // EPC wrap-around for a delay-slot AdEL at a misaligned low PC
      Err = 1'b1; ExcCodeIn = 5'd4; BD = 1'b1; VPC = 32'h0000_0002;
      exp_irq("wrap_irq", 1'b1);
      drain();
      tick();
      idle();
      exp_rd("wrap_epc", 5'd14, 32'hffff_fffe);
      exp_rd("wrap_cause", 5'd13, 32'h8000_0010);
      drain();

      // Reset mid-exception (EXL=1 here) with Err and eret both pending
      reset = 1'b1; Err = 1'b1; EXLClr = 1'b1; HWInt = 6'h3f;
      tick();
      idle();
      exp_irq("rst2_irq", 1'b0);
      exp_rd("rst2_sr", 5'd12, 32'h0);
      exp_rd("rst2_cause", 5'd13, 32'h0);
      exp_rd("rst2_epc", 5'd14, 32'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
